ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between the processor core and the external
//  host port (EX_ADDRESS/EX_DATA path used for loading and dumping image data).
//  Sits between PROCESSOR's memory interface and the RAM instance.
//  - While processing: core has priority, with a starvation guard for the host.
//  - After PROCESS_DONE: requesters alternate round-robin.
//  Routes each read return to its owner.
// PARAMETERS
//  ADDR_W    16  RAM address width
//  DATA_W    8   RAM data width
//  MAX_WAIT  15  cycles the host may wait while core has priority before a forced grant (>=1)
// PORTS
//  MAIN_CLOCK    in   1       single clock, all logic on rising edge
//  MAIN_RESET_N  in   1       synchronous, active-low reset
//  PROCESS_DONE  in   1       core finished; selects round-robin mode
//  CORE_REQ      in   1       core access request; held until CORE_GNT
//  CORE_WE       in   1       1=write, 0=read (valid with CORE_REQ)
//  CORE_ADDR     in   ADDR_W  core address
//  CORE_WDATA    in   DATA_W  core write data
//  CORE_GNT      out  1       core access issued this cycle
//  CORE_RVALID   out  1       CORE_RDATA valid (read return)
//  CORE_RDATA    out  DATA_W  read data to core
//  EX_REQ, EX_WE, EX_ADDR, EX_WDATA   in   host equivalents of CORE_* inputs
//  EX_GNT, EX_RVALID                  out  1        host equivalents
//  EX_RDATA                           out  DATA_W   host equivalent
//  RAM_EN        out  1       RAM access strobe
//  RAM_WE        out  1       RAM write enable
//  RAM_ADDR      out  ADDR_W  RAM address
//  RAM_WDATA     out  DATA_W  RAM write data
//  RAM_RDATA     in   DATA_W  RAM read data, valid 1 cycle after RAM_EN & !RAM_WE
// BEHAVIOUR
//  - Grant is combinational from current REQs and registered state. At most one GNT per cycle.
//  - RAM_EN = CORE_GNT | EX_GNT. RAM_WE/ADDR/WDATA are muxed from the granted requester.
//  - Idle RAM_ADDR/RAM_WDATA = 0.
//  - Arbitration:
//    - Only one REQ: grant it.
//    - Both REQ, PROCESS_DONE=0: core wins unless WAIT_CNT==MAX_WAIT, then host wins.
//    - Both REQ, PROCESS_DONE=1: the requester not in LAST_GNT wins.
//    - LAST_GNT updates on every grant.
//  - WAIT_CNT (ceil(log2(MAX_WAIT+1)) bits):
//    - +1 per cycle with EX_REQ & !EX_GNT, saturating at MAX_WAIT.
//    - Clears on EX_GNT or !EX_REQ.
//  - Read return, fixed latency 1:
//    - Registered RD_PEND and RD_OWNER are set on a read grant.
//    - Next cycle: RVALID=1 to the owner only, other RVALID=0.
//    - CORE_RDATA and EX_RDATA both = RAM_RDATA. Back-to-back reads give RVALID every cycle.
//  - Writes produce no RVALID. No address hazard checking: the RAM is read-after-write ordered by issue order.
//  - PROCESS_DONE may toggle at any cycle; the new mode applies the same cycle.
//  - Reset (MAIN_RESET_N=0 at an edge):
//    - RD_PEND=0, WAIT_CNT=0, LAST_GNT=CORE (host wins the first round-robin tie).
//    - While MAIN_RESET_N=0, both GNT, RAM_EN and RAM_WE are forced 0.
//  - Reset mid-operation: a read granted the cycle before reset asserts has its RVALID suppressed.
//  - Address wrap: none internal; addresses pass through unchanged (0xFFFF legal).
// STRUCTURE
//  - Shared package mem_pkg: ADDR_W/DATA_W defaults, owner encoding OWN_CORE=1'b0 / OWN_EX=1'b1.
//  - One natural sub-module: arb_rr2 (2-way grant logic with priority/round-robin mode and starvation input).
//  - Return tag, counter and muxes stay in this top module.
// TESTING
//  1. Reset held with CORE_REQ=EX_REQ=1 -> both GNT=0, RAM_EN=0, both RVALID=0. On release, core granted first cycle (PROCESS_DONE=0).
//  2. Core read 0x0010 alone -> CORE_GNT same cycle, RAM_ADDR=0x0010, RAM_WE=0. Next cycle CORE_RVALID=1, CORE_RDATA=RAM_RDATA, EX_RVALID=0.
//  3. PROCESS_DONE=0, both REQ continuous, MAX_WAIT=15 -> 15 core grants, then 1 host grant, pattern repeats.
//  4. PROCESS_DONE=1, both REQ continuous from reset -> grants EX,CORE,EX,CORE...
//  5. Host dump sweep reads 2,6,10..0xFFFE, one per cycle -> EX_RVALID every cycle, 1 cycle after each grant. Last address 0xFFFE returns correctly.
//  6. Core write 0x0100=0xAA and host read 0x0100 both requested, PROCESS_DONE=0:
//     - Write issued first, read next cycle -> EX_RDATA=0xAA.
//     - Reset asserted during that read's return cycle -> EX_RVALID=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared RAM address/data widths and read-owner encoding (OWN_CORE/OWN_EX)
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  typedef enum logic {OWN_CORE = 1'b0, OWN_EX = 1'b1} owner_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's RAM port (req/we/addr/wdata in, gnt/rvalid/rdata out); master=requester, slave=arbiter
interface ram_port_arbiter_if import mem_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter_arb_rr2.sv
// arb_rr2: 2-way grant (req_c/req_e, rr_mode, starve, last_gnt -> gnt_c/gnt_e), core priority with starvation override or round-robin
module arb_rr2 import mem_pkg::*; (
  input  logic   req_c,
  input  logic   req_e,
  input  logic   rr_mode,
  input  logic   starve,
  input  owner_t last_gnt,
  output logic   gnt_c,
  output logic   gnt_e
);
  logic host_wins;
  always_comb begin
    host_wins = req_c ? (rr_mode ? last_gnt == OWN_CORE : starve) : 1'b1;
    gnt_e = req_e & host_wins;
    gnt_c = req_c & ~gnt_e;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM between core and host ports (MAIN_CLOCK, MAIN_RESET_N, PROCESS_DONE, core/ex slave ifs, RAM_EN/WE/ADDR/WDATA out, RAM_RDATA in)
module ram_port_arbiter import mem_pkg::*; #(
  parameter int MAX_WAIT = 15
) (
  input  logic              MAIN_CLOCK,
  input  logic              MAIN_RESET_N,
  input  logic              PROCESS_DONE,
  ram_port_arbiter_if.slave core,
  ram_port_arbiter_if.slave ex,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  owner_t        last_gnt;
  owner_t        rd_owner;
  logic          rd_pend;
  logic          gnt_c;
  logic          gnt_e;
  logic          starve;
  assign starve = wait_cnt == WW'(MAX_WAIT);
  arb_rr2 u_arb (
    .req_c    (core.req),
    .req_e    (ex.req),
    .rr_mode  (PROCESS_DONE),
    .starve   (starve),
    .last_gnt (last_gnt),
    .gnt_c    (gnt_c),
    .gnt_e    (gnt_e)
  );
  assign core.gnt  = gnt_c & MAIN_RESET_N;
  assign ex.gnt    = gnt_e & MAIN_RESET_N;
  assign RAM_EN    = core.gnt | ex.gnt;
  assign RAM_WE    = core.gnt ? core.we : ex.gnt & ex.we;
  assign RAM_ADDR  = core.gnt ? core.addr : ex.gnt ? ex.addr : '0;
  assign RAM_WDATA = core.gnt ? core.wdata : ex.gnt ? ex.wdata : '0;
  // gating with reset kills the return of a read issued just before reset
  assign core.rvalid = rd_pend & (rd_owner == OWN_CORE) & MAIN_RESET_N;
  assign ex.rvalid   = rd_pend & (rd_owner == OWN_EX) & MAIN_RESET_N;
  assign core.rdata  = RAM_RDATA;
  assign ex.rdata    = RAM_RDATA;
  always_ff @(posedge MAIN_CLOCK) begin
    if (!MAIN_RESET_N) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CORE;
      wait_cnt <= '0;
      last_gnt <= OWN_CORE;
    end else begin
      rd_pend  <= RAM_EN & ~RAM_WE;
      rd_owner <= ex.gnt ? OWN_EX : OWN_CORE;
      if (RAM_EN) last_gnt <= ex.gnt ? OWN_EX : OWN_CORE;
      wait_cnt <= (ex.gnt | ~ex.req) ? '0 : starve ? wait_cnt : wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with a behavioural arbitration/RAM model checked every cycle
module tb_ram_port_arbiter;
  localparam int MAX_WAIT = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  logic ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  int total = 0;
  int bad = 0;
  bit [7:0] mem [65536];
  bit wr [65536];
  int m_last = 0;
  int m_wait = 0;
  int m_pend = 0;
  logic [7:0] m_pdata = 8'h00;
  ram_port_arbiter_if core_if ();
  ram_port_arbiter_if ex_if ();
  ram_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .MAIN_CLOCK   (clk),
    .MAIN_RESET_N (rst_n),
    .PROCESS_DONE (done),
    .core         (core_if),
    .ex           (ex_if),
    .RAM_EN       (ram_en),
    .RAM_WE       (ram_we),
    .RAM_ADDR     (ram_addr),
    .RAM_WDATA    (ram_wdata),
    .RAM_RDATA    (ram_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rd(logic [15:0] a);
    return wr[a] ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= rd(ram_addr);
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr[ram_addr] <= 1'b1;
    end
  end
  // {core grant, host grant} that the arbitration rules demand right now
  function automatic logic [1:0] arb();
    logic hw;
    if (!rst_n) return 2'b00;
    if (core_if.req && ex_if.req) hw = done ? (m_last == 0) : (m_wait >= MAX_WAIT);
    else hw = ex_if.req;
    return {core_if.req && !hw, hw};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    logic [1:0] g;
    g = arb();
    if (!rst_n) begin
      m_last = 0;
      m_wait = 0;
      m_pend = 0;
    end else begin
      m_pend = 0;
      if (g[1] && !core_if.we) begin m_pend = 1; m_pdata = rd(core_if.addr); end
      if (g[0] && !ex_if.we) begin m_pend = 2; m_pdata = rd(ex_if.addr); end
      if (g != 2'b00) m_last = g[0] ? 1 : 0;
      m_wait = (ex_if.req && !g[0]) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : m_wait) : 0;
    end
  end
  always @(negedge clk) begin
    logic [1:0] g;
    g = arb();
    chk("gnt", {core_if.gnt, ex_if.gnt}, g);
    chk("ram_en", ram_en, |g);
    chk("ram_we", ram_we, g[1] ? core_if.we : (g[0] & ex_if.we));
    chk("ram_addr", ram_addr, g[1] ? core_if.addr : g[0] ? ex_if.addr : 16'h0);
    chk("ram_wdata", ram_wdata, g[1] ? core_if.wdata : g[0] ? ex_if.wdata : 8'h0);
    chk("core_rvalid", core_if.rvalid, rst_n && m_pend == 1);
    chk("ex_rvalid", ex_if.rvalid, rst_n && m_pend == 2);
    if (rst_n && m_pend == 1) chk("core_rdata", core_if.rdata, m_pdata);
    if (rst_n && m_pend == 2) chk("ex_rdata", ex_if.rdata, m_pdata);
  end
  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask
  task automatic sample();
    @(negedge clk);
    #1;
  endtask
  initial begin
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 16'h0010; core_if.wdata = 8'h00;
    ex_if.req = 1'b1; ex_if.we = 1'b0; ex_if.addr = 16'h0020; ex_if.wdata = 8'h00;
    repeat (3) edge_in();
    sample();
    chk("rst_quiet", {core_if.gnt, ex_if.gnt, ram_en, ram_we, core_if.rvalid, ex_if.rvalid}, 6'b0);
    edge_in();
    rst_n = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) edge_in();
      sample();
      chk("prio_core_gnt", core_if.gnt, (i % 16) != 15);
      chk("prio_ex_gnt", ex_if.gnt, (i % 16) == 15);
    end
    edge_in();
    rst_n = 1'b0; core_if.req = 1'b0; ex_if.req = 1'b0;
    edge_in();
    rst_n = 1'b1; core_if.req = 1'b1; core_if.addr = 16'h0010;
    sample();
    chk("rd10_gnt", core_if.gnt, 1'b1);
    chk("rd10_addr", ram_addr, 16'h0010);
    chk("rd10_we", ram_we, 1'b0);
    edge_in();
    core_if.req = 1'b0;
    sample();
    chk("rd10_rvalid", {core_if.rvalid, ex_if.rvalid}, 2'b10);
    chk("rd10_data", core_if.rdata, 8'h4A);
    edge_in();
    rst_n = 1'b0;
    edge_in();
    rst_n = 1'b1; done = 1'b1; core_if.req = 1'b1; ex_if.req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) edge_in();
      sample();
      chk("rr_ex_gnt", ex_if.gnt, (i % 2) == 0);
      chk("rr_core_gnt", core_if.gnt, (i % 2) == 1);
    end
    edge_in();
    done = 1'b0; core_if.req = 1'b0; ex_if.req = 1'b1;
    for (int a = 2; a <= 16'hFFFE; a += 4) begin
      ex_if.addr = 16'(a);
      edge_in();
    end
    ex_if.req = 1'b0;
    sample();
    chk("sweep_last_rvalid", ex_if.rvalid, 1'b1);
    chk("sweep_last_data", ex_if.rdata, 8'h5B);
    edge_in();
    core_if.req = 1'b1; core_if.we = 1'b1; core_if.addr = 16'h0100; core_if.wdata = 8'hAA;
    ex_if.req = 1'b1; ex_if.we = 1'b0; ex_if.addr = 16'h0100;
    sample();
    chk("raw_wr_first", {core_if.gnt, ex_if.gnt, ram_we}, 3'b101);
    edge_in();
    core_if.req = 1'b0;
    sample();
    chk("raw_rd_next", ex_if.gnt, 1'b1);
    edge_in();
    ex_if.req = 1'b0;
    sample();
    chk("raw_rvalid", ex_if.rvalid, 1'b1);
    chk("raw_data", ex_if.rdata, 8'hAA);
    edge_in();
    core_if.req = 1'b1; core_if.wdata = 8'h33; ex_if.req = 1'b1;
    sample();
    chk("rst_wr_first", core_if.gnt, 1'b1);
    edge_in();
    core_if.req = 1'b0;
    sample();
    chk("rst_rd_next", ex_if.gnt, 1'b1);
    edge_in();
    ex_if.req = 1'b0; rst_n = 1'b0;
    sample();
    chk("rst_kills_rvalid", ex_if.rvalid, 1'b0);
    edge_in();
    rst_n = 1'b1;
    sample();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
